// File: rtl/mcu_register_bridge.sv
// mcu_register_bridge: decodes the QSPI byte stream from the MCU into register
// accesses. It holds an RW config bank, a read-only status window, an ID word
// and a maskable edge-latched interrupt controller.
// Optional feature: define MCU_BRIDGE_AUTOINC_EN to post-increment the register
// address after every data byte of 0x02 and every read byte of 0x03.
module mcu_register_bridge #(
  parameter int          NUM_REGS   = 16,
  parameter int          ADDR_BYTES = 1,
  parameter int          IRQ_COUNT  = 4,
  parameter logic [31:0] ID_WORD    = 32'hfeedface,
  parameter logic [7:0]  REG_RESET  = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  insn_valid,
  input  logic [7:0]            insn,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  output logic                  rd_mode,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  output logic [NUM_REGS*8-1:0] reg_out,
  input  logic [NUM_REGS*8-1:0] reg_in,
  input  logic [IRQ_COUNT-1:0]  irq_src,
  output logic                  irq
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
`ifdef MCU_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [7:0] OP_ID       = 8'hAA;
  localparam logic [7:0] OP_WR       = 8'h02;
  localparam logic [7:0] OP_RD       = 8'h03;
  localparam logic [7:0] OP_IRQ_RD   = 8'h10;
  localparam logic [7:0] OP_IRQ_CLR  = 8'h11;
  localparam logic [7:0] OP_IRQ_MASK = 8'h12;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DISCARD} state_t;

  state_t               state;
  logic [7:0]           opcode;
  logic [AW-1:0]        addr;
  logic [AW-1:0]        addr_next;
  logic [1:0]           cnt;
  logic [7:0]           regs [NUM_REGS];
  logic [IRQ_COUNT-1:0] pending;
  logic [IRQ_COUNT-1:0] mask;
  logic [IRQ_COUNT-1:0] irq_src_d;
  logic [IRQ_COUNT-1:0] irq_rise;
  logic [IRQ_COUNT-1:0] irq_clr;
  logic [31:0]          addr_ext;
  logic [IW-1:0]        reg_idx;
  logic [IW-1:0]        in_idx;
  logic [7:0]           read_byte;
  logic                 wr_fire;
  logic                 in_range;

  // Address bytes arrive MSB first: shift the new byte in at the bottom.
  generate
    if (AW == 8) begin : g_addr1
      assign addr_next = wr_data;
    end else begin : g_addrn
      assign addr_next = {addr[AW-9:0], wr_data};
    end
  endgenerate

  // Flatten the config bank onto reg_out.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      assign reg_out[8*gi +: 8] = regs[gi];
    end
  endgenerate

  assign addr_ext = 32'(addr);
  assign reg_idx  = addr[IW-1:0];
  // Difference fits in IW bits whenever the status window is selected.
  assign in_idx   = addr[IW-1:0] - IW'(NUM_REGS);
  assign in_range = addr_ext < 32'(NUM_REGS);
  assign wr_fire  = !start && (state == WDATA) && wr_valid;
  assign irq_clr  = (wr_fire && opcode == OP_IRQ_CLR) ? wr_data[IRQ_COUNT-1:0] : '0;
  assign irq_rise = irq_src & ~irq_src_d;

  // Byte presented on the next rd_ready; zero outside the read phase.
  always_comb begin
    read_byte = 8'h00;
    if (state == RDATA) begin
      case (opcode)
        OP_ID: begin
          case (cnt)
            2'd0:    read_byte = ID_WORD[31:24];
            2'd1:    read_byte = ID_WORD[23:16];
            2'd2:    read_byte = ID_WORD[15:8];
            default: read_byte = ID_WORD[7:0];
          endcase
        end
        OP_IRQ_RD: read_byte = 8'(pending);
        OP_RD: begin
          if (in_range)
            read_byte = regs[reg_idx];
          else if (addr_ext < 32'(2 * NUM_REGS))
            read_byte = reg_in[{in_idx, 3'b000} +: 8];
        end
        default: read_byte = 8'h00;
      endcase
    end
  end

  // Command FSM: opcode/address decode, register and mask writes, burst address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      opcode  <= 8'h00;
      addr    <= '0;
      cnt     <= 2'd0;
      rd_mode <= 1'b0;
      mask    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RESET;
    end else begin
      rd_mode <= (state == RDATA) && !start;
      if (start) begin
        state <= IDLE;
        cnt   <= 2'd0;
        addr  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (insn_valid) begin
              opcode <= insn;
              cnt    <= 2'd0;
              case (insn)
                OP_WR, OP_RD:            state <= ADDR;
                OP_IRQ_CLR, OP_IRQ_MASK: state <= WDATA;
                OP_ID, OP_IRQ_RD:        state <= RDATA;
                default:                 state <= DISCARD;
              endcase
            end
          end
          ADDR: begin
            if (wr_valid) begin
              addr <= addr_next;
              if (cnt == 2'(ADDR_BYTES - 1)) begin
                cnt   <= 2'd0;
                state <= (opcode == OP_WR) ? WDATA : RDATA;
              end else begin
                cnt <= cnt + 2'd1;
              end
            end
          end
          WDATA: begin
            if (wr_valid) begin
              if (opcode == OP_WR) begin
                if (in_range) regs[reg_idx] <= wr_data;
                if (AUTOINC) addr <= addr + AW'(1);
              end else if (opcode == OP_IRQ_MASK) begin
                mask <= wr_data[IRQ_COUNT-1:0];
              end
            end
          end
          RDATA: begin
            if (rd_ready) begin
              if (opcode == OP_ID) cnt <= cnt + 2'd1;
              if (AUTOINC && opcode == OP_RD) addr <= addr + AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read response: one-cycle strobe per rd_ready; data holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      rd_valid <= rd_ready;
      if (rd_ready) rd_data <= read_byte;
    end
  end

  // Interrupts: rising edges latch into pending (set beats W1C), irq registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_src_d <= '0;
      pending   <= '0;
      irq       <= 1'b0;
    end else begin
      irq_src_d <= irq_src;
      pending   <= (pending & ~irq_clr) | irq_rise;
      irq       <= |(pending & mask);
    end
  end

endmodule

// File: tb/tb_mcu_register_bridge.sv
// Self-checking bench for mcu_register_bridge (default parameters).
// Follows MCU_BRIDGE_AUTOINC_EN to pick the expected burst behaviour.
module tb_mcu_register_bridge;

  localparam int          NR = 16;
  localparam int          IC = 4;
  localparam logic [31:0] ID = 32'hfeedface;
`ifdef MCU_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          insn_valid = 1'b0;
  logic [7:0]    insn = 8'h00;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          rd_mode;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic [NR*8-1:0] reg_out;
  logic [NR*8-1:0] reg_in = '0;
  logic [IC-1:0] irq_src = '0;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]    m_regs [NR];
  logic [IC-1:0] m_pend;
  logic [IC-1:0] m_mask;

  always #5 clk = ~clk;

  mcu_register_bridge #(
    .NUM_REGS(NR), .ADDR_BYTES(1), .IRQ_COUNT(IC), .ID_WORD(ID), .REG_RESET(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .insn_valid(insn_valid), .insn(insn),
    .wr_valid(wr_valid), .wr_data(wr_data), .rd_mode(rd_mode), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .reg_out(reg_out), .reg_in(reg_in),
    .irq_src(irq_src), .irq(irq)
  );

  function automatic logic [NR*8-1:0] m_bank();
    logic [NR*8-1:0] b;
    for (int i = 0; i < NR; i++) b[8*i +: 8] = m_regs[i];
    return b;
  endfunction

  function automatic logic [7:0] m_read(input int a);
    if (a < NR) return m_regs[a];
    if (a < 2*NR) return reg_in[8*(a-NR) +: 8];
    return 8'h00;
  endfunction

  function automatic logic [7:0] id_byte(input int i);
    logic [31:0] w;
    w = ID >> (8 * (3 - (i % 4)));
    return w[7:0];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_pend = '0;
    m_mask = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic [IC-1:0] v);
    m_pend  = m_pend | (v & ~irq_src);
    irq_src = v;
  endtask

  task automatic begin_txn(input logic [7:0] op);
    start = 1'b1; cyc(); start = 1'b0;
    insn = op; insn_valid = 1'b1; cyc(); insn_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    wr_data = b; wr_valid = 1'b1; cyc(); wr_valid = 1'b0;
  endtask

  task automatic pull(output logic v, output logic [7:0] d);
    rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    v = rd_valid; d = rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_reset();
    repeat (3) cyc();
    n_cmp++; if (rd_mode !== 1'b0) begin n_err++; $display("FAIL reset_rd_mode got=%b exp=0", rd_mode); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
    n_cmp++; if (reg_out !== m_bank()) begin n_err++; $display("FAIL reset_reg_out got=%h exp=%h", reg_out, m_bank()); end
    rst_n = 1'b1; cyc();
    $display("txn reset done");
  endtask

  task automatic test_id();
    logic v; logic [7:0] d;
    begin_txn(8'hAA);
    n_cmp++; if (rd_mode !== 1'b0) begin n_err++; $display("FAIL id_rd_mode_entry got=%b exp=0", rd_mode); end
    cyc();
    n_cmp++; if (rd_mode !== 1'b1) begin n_err++; $display("FAIL id_rd_mode got=%b exp=1", rd_mode); end
    for (int i = 0; i < 6; i++) begin
      pull(v, d);
      n_cmp++;
      if (v !== 1'b1 || d !== id_byte(i)) begin
        n_err++; $display("FAIL id_byte%0d got=%b/%h exp=1/%h", i, v, d, id_byte(i));
      end
      $display("txn id read %0d -> %h", i, d);
    end
    cyc();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL id_valid_pulse got=%b exp=0", rd_valid); end
  endtask

  task automatic test_reg_rw();
    logic v; logic [7:0] d;
    begin_txn(8'h02); send(8'h03); send(8'h5A); m_regs[3] = 8'h5A;
    n_cmp++; if (reg_out[31:24] !== 8'h5A) begin n_err++; $display("FAIL wr_reg3 got=%h exp=5a", reg_out[31:24]); end
    begin_txn(8'h03); send(8'h03); pull(v, d);
    n_cmp++; if (v !== 1'b1 || d !== 8'h5A) begin n_err++; $display("FAIL rd_reg3 got=%b/%h exp=1/5a", v, d); end
    reg_in = {$urandom, $urandom, $urandom, $urandom};
    begin_txn(8'h03); send(8'h13); pull(v, d);
    n_cmp++; if (d !== reg_in[31:24]) begin n_err++; $display("FAIL rd_status3 got=%h exp=%h", d, reg_in[31:24]); end
    begin_txn(8'h03); send(8'h40); pull(v, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL rd_out_of_range got=%h exp=00", d); end
    $display("txn reg rw done");
  endtask

  task automatic test_burst();
    begin_txn(8'h02); send(8'h0E); send(8'h11); send(8'h22); send(8'h33);
    if (AUTOINC) begin m_regs[14] = 8'h11; m_regs[15] = 8'h22; end
    else m_regs[14] = 8'h33;
    n_cmp++; if (reg_out !== m_bank()) begin n_err++; $display("FAIL burst_bank got=%h exp=%h", reg_out, m_bank()); end
    $display("txn burst reg14=%h reg15=%h", reg_out[119:112], reg_out[127:120]);
  endtask

  task automatic test_random();
    int a; int len; logic v; logic [7:0] d; logic [7:0] e;
    for (int it = 0; it < 24; it++) begin
      a = $urandom_range(0, 40);
      len = $urandom_range(1, 3);
      reg_in = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        begin_txn(8'h02); send(8'(a));
        for (int k = 0; k < len; k++) begin
          d = 8'($urandom);
          send(d);
          if (a < NR) m_regs[a] = d;
          if (AUTOINC) a = (a + 1) % 256;
        end
        n_cmp++;
        if (reg_out !== m_bank()) begin n_err++; $display("FAIL rand_wr%0d got=%h exp=%h", it, reg_out, m_bank()); end
        $display("txn rand write it=%0d len=%0d", it, len);
      end else begin
        begin_txn(8'h03); send(8'(a));
        for (int k = 0; k < len; k++) begin
          e = m_read(a);
          pull(v, d);
          n_cmp++;
          if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL rand_rd%0d addr=%0d got=%b/%h exp=1/%h", it, a, v, d, e); end
          if (AUTOINC) a = (a + 1) % 256;
        end
        $display("txn rand read it=%0d len=%0d", it, len);
      end
    end
  endtask

  task automatic test_irq();
    logic v; logic [7:0] d;
    set_src(4'b0100); repeat (3) cyc();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_masked got=%b exp=0", irq); end
    begin_txn(8'h12); send(8'h04); m_mask = 4'b0100; cyc();
    n_cmp++; if (irq !== |(m_pend & m_mask)) begin n_err++; $display("FAIL irq_unmasked got=%b exp=%b", irq, |(m_pend & m_mask)); end
    begin_txn(8'h10); pull(v, d);
    n_cmp++; if (d !== 8'(m_pend)) begin n_err++; $display("FAIL irq_pending_rd got=%h exp=%h", d, 8'(m_pend)); end
    begin_txn(8'h11); send(8'h04); m_pend = m_pend & ~4'b0100;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_clr_lag got=%b exp=1", irq); end
    cyc();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared got=%b exp=0", irq); end
    // W1C of bit1 coinciding with a fresh rising edge on irq_src[1]
    set_src(4'b0110); repeat (2) cyc();
    set_src(4'b0100); cyc();
    begin_txn(8'h11);
    wr_data = 8'h02; wr_valid = 1'b1;
    m_pend = m_pend & ~4'b0010;
    set_src(4'b0110);
    cyc(); wr_valid = 1'b0;
    begin_txn(8'h10); pull(v, d);
    n_cmp++; if (d !== 8'(m_pend)) begin n_err++; $display("FAIL irq_set_wins got=%h exp=%h", d, 8'(m_pend)); end
    begin_txn(8'h12); send(8'h02); m_mask = 4'b0010; cyc();
    n_cmp++; if (irq !== |(m_pend & m_mask)) begin n_err++; $display("FAIL irq_bit1 got=%b exp=%b", irq, |(m_pend & m_mask)); end
    $display("txn irq pending=%h", d);
  endtask

  task automatic test_discard();
    logic v; logic [7:0] d;
    begin_txn(8'h7F); send(8'h01); send(8'hA5); send(8'h3C); cyc();
    n_cmp++; if (reg_out !== m_bank()) begin n_err++; $display("FAIL discard_bank got=%h exp=%h", reg_out, m_bank()); end
    n_cmp++; if (rd_mode !== 1'b0) begin n_err++; $display("FAIL discard_rd_mode got=%b exp=0", rd_mode); end
    pull(v, d);
    n_cmp++; if (v !== 1'b1 || d !== 8'h00) begin n_err++; $display("FAIL discard_read got=%b/%h exp=1/00", v, d); end
    $display("txn discard done");
  endtask

  task automatic test_abort();
    begin_txn(8'h02); send(8'h05); send(8'hC3); m_regs[5] = 8'hC3;
    start = 1'b1; cyc(); start = 1'b0;
    send(8'h99);
    begin_txn(8'h02);
    start = 1'b1; cyc(); start = 1'b0;
    send(8'h06); send(8'h77);
    n_cmp++; if (reg_out !== m_bank()) begin n_err++; $display("FAIL abort_bank got=%h exp=%h", reg_out, m_bank()); end
    $display("txn abort done");
  endtask

  task automatic test_async_reset();
    logic v; logic [7:0] d;
    begin_txn(8'hAA); cyc(); pull(v, d);
    #2 rst_n = 1'b0; m_reset();
    #1;
    n_cmp++; if (rd_mode !== 1'b0) begin n_err++; $display("FAIL areset_rd_mode got=%b exp=0", rd_mode); end
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL areset_rd_data got=%h exp=00", rd_data); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL areset_irq got=%b exp=0", irq); end
    n_cmp++; if (reg_out !== m_bank()) begin n_err++; $display("FAIL areset_reg_out got=%h exp=%h", reg_out, m_bank()); end
    irq_src = '0;
    cyc(); rst_n = 1'b1; cyc();
    $display("txn async reset done");
  endtask

  initial begin
    test_reset();
    test_id();
    test_reg_rw();
    test_burst();
    test_random();
    test_irq();
    test_discard();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
